// File: rtl/cmp_pkg.sv
// Shared types for the parallel/serial comparator family.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_t;

  typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;

  // One LSB-first step: a differing bit pair overrides whatever the lower bits decided.
  // swap inverts the ordering for a two's-complement sign bit.
  function automatic cmp_res_t cmp_step(input cmp_res_t cur, input logic a, input logic b,
                                        input logic swap);
    cmp_res_t r;
    r = cur;
    if (a && !b) begin
      r = swap ? CMP_LT : CMP_GT;
    end else if (!a && b) begin
      r = swap ? CMP_GT : CMP_LT;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmp_serial_mag.sv
// Bit-serial magnitude comparator: LSB-first operand bit pairs in, one-hot eq/gt/lt out.
// Latency: done one cycle after the final accepted beat (WIDTH+1 cycles minimum from start).
// Backpressure: bit_ready high for the whole of SHIFT; idle bit_valid cycles simply stretch it.
module cmp_serial_mag
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic lt
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  cmp_state_t    state, state_nxt;
  cmp_res_t      code, code_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_beat;

  assign last_beat = (cnt == LAST);
  assign code_nxt  = cmp_step(code, a_bit, b_bit, SIGNED && last_beat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort wins over a beat arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_valid) begin
          accept = 1'b1;
          if (last_beat) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      code <= CMP_EQ;
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt  <= '0;
      code <= CMP_EQ;
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else if (accept) begin
      code <= code_nxt;
      cnt  <= last_beat ? '0 : cnt + CW'(1);
      if (last_beat) begin
        eq <= (code_nxt == CMP_EQ);
        gt <= (code_nxt == CMP_GT);
        lt <= (code_nxt == CMP_LT);
      end
    end
  end

endmodule

// File: tb/tb_cmp_serial_mag.sv
// Self-checking bench: unsigned and signed instances fed the same bit stream.
// Directed vector table, hand-written corner sequences, then randomized pairs vs a reference compare.
module tb_cmp_serial_mag;

  localparam int W = 16;

  logic clk;
  logic rst_n, start, abort, bit_valid, a_bit, b_bit;
  logic bit_ready_u, busy_u, done_u, eq_u, gt_u, lt_u;
  logic bit_ready_s, busy_s, done_s, eq_s, gt_s, lt_s;

  int n_cmp = 0;
  int n_err = 0;

  cmp_serial_mag #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .bit_ready(bit_ready_u), .busy(busy_u), .done(done_u),
    .eq(eq_u), .gt(gt_u), .lt(lt_u)
  );

  cmp_serial_mag #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .bit_ready(bit_ready_s), .busy(busy_s), .done(done_s),
    .eq(eq_s), .gt(gt_s), .lt(lt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           gap;    // 0 contiguous, 1 toggling, 2 random
    logic [2:0]   exp_u;  // {eq,gt,lt}
    logic [2:0]   exp_s;
  } vec_t;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit sgn);
    int sa, sb;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    if (sa > sb) return R_GT;
    if (sa < sb) return R_LT;
    return R_EQ;
  endfunction

  task automatic do_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gap, input bit start_in_done, input logic [2:0] exp_u,
                        input logic [2:0] exp_s, input bit chk_lat);
    int  nacc, cyc, guard, early, rdy_bad;
    bit  v;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_ready"}, {busy_u, busy_s, bit_ready_u, bit_ready_s}, 4'hf);
    nacc = 0; guard = 0; early = 0; rdy_bad = 0;
    while (nacc < W && guard < 2000) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bit_valid = v;
      a_bit = v ? a[nacc] : 1'($urandom);
      b_bit = v ? b[nacc] : 1'($urandom);
      if (!bit_ready_u || !bit_ready_s) rdy_bad++;
      if (done_u || done_s) early++;
      step();
      cyc++;
      guard++;
      if (v) nacc++;
    end
    bit_valid = 1'b0;
    chk({tag, "_timeout"}, nacc, W);
    chk({tag, "_no_early_done"}, early, 0);
    if (gap != 0) chk({tag, "_ready_held"}, rdy_bad, 0);
    if (chk_lat) chk({tag, "_latency"}, cyc, W + 1);
    chk({tag, "_done_busy"}, {done_u, done_s, busy_u, busy_s}, 4'hf);
    chk({tag, "_res_u"}, {eq_u, gt_u, lt_u}, exp_u);
    chk({tag, "_res_s"}, {eq_s, gt_s, lt_s}, exp_s);
    start = start_in_done;
    step();
    start = 1'b0;
    chk({tag, "_idle_after"}, {done_u, done_s, busy_u, busy_s, bit_ready_u, bit_ready_s}, 6'h0);
    chk({tag, "_held"}, {eq_u, gt_u, lt_u, eq_s, gt_s, lt_s}, {exp_u, exp_s});
  endtask

  vec_t vecs[8];

  initial begin
    int   seen;
    logic [W-1:0] ra, rb, av;

    vecs[0] = '{16'h1234, 16'h1234, 0, R_EQ, R_EQ};
    vecs[1] = '{16'h8000, 16'h7FFF, 0, R_GT, R_LT};
    vecs[2] = '{16'h0001, 16'h0002, 0, R_LT, R_LT};
    vecs[3] = '{16'hFFFE, 16'hFFFF, 1, R_LT, R_LT};
    vecs[4] = '{16'h0000, 16'h0000, 0, R_EQ, R_EQ};
    vecs[5] = '{16'hFFFF, 16'h0000, 2, R_GT, R_LT};
    vecs[6] = '{16'h7FFF, 16'h8000, 0, R_LT, R_GT};
    vecs[7] = '{16'h8001, 16'h8000, 1, R_GT, R_GT};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (3) step();
    chk("reset_outputs",
        {bit_ready_u, busy_u, done_u, eq_u, gt_u, lt_u, bit_ready_s, busy_s, done_s, eq_s, gt_s, lt_s},
        12'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      do_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].gap, 1'b0,
             vecs[i].exp_u, vecs[i].exp_s, vecs[i].gap == 0);
    end

    // Abort together with the 8th beat.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      step();
    end
    abort = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    step();
    abort = 1'b0;
    chk("abort_busy", {busy_u, busy_s, bit_ready_u, bit_ready_s, done_u, done_s}, 6'h0);
    chk("abort_res", {eq_u, gt_u, lt_u, eq_s, gt_s, lt_s}, 6'h0);
    seen = 0;
    repeat (20) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      if (done_u || done_s || busy_u || busy_s) seen++;
      step();
    end
    bit_valid = 1'b0;
    chk("abort_no_done", seen, 0);
    do_cmp("after_abort", 16'h0000, 16'h0000, 0, 1'b0, R_EQ, R_EQ, 1'b1);

    // Reset mid-comparison after 10 beats.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bit_valid = 1'b0;
    chk("midreset_outputs",
        {bit_ready_u, busy_u, done_u, eq_u, gt_u, lt_u, bit_ready_s, busy_s, done_s, eq_s, gt_s, lt_s},
        12'h0);
    step();

    // start during DONE must not launch a new comparison.
    do_cmp("start_in_done", 16'h00F0, 16'h0F00, 0, 1'b1, R_LT, R_LT, 1'b1);

    // Repeated start in SHIFT: neither counter nor running code is cleared.
    av = 16'h0010;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; a_bit = av[i]; b_bit = 1'b0;
      step();
    end
    bit_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 5; i < W; i++) begin
      bit_valid = 1'b1; a_bit = av[i]; b_bit = 1'b0;
      if (done_u || done_s) seen++;
      step();
    end
    bit_valid = 1'b0;
    chk("restart_no_early_done", seen, 0);
    chk("restart_done", {done_u, done_s}, 2'b11);
    chk("restart_res", {eq_u, gt_u, lt_u, eq_s, gt_s, lt_s}, {R_GT, R_GT});
    step();

    // Randomized operand pairs with random valid gaps.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, W - 1));
        default: rb = 16'($urandom);
      endcase
      do_cmp($sformatf("rnd%0d", i), ra, rb, 2, 1'($urandom), ref_res(ra, rb, 1'b0),
             ref_res(ra, rb, 1'b1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_serial_mag.md
# cmp_serial_mag

Bit-serial magnitude comparator. It is the receiving end of a serialised operand link: it consumes two WIDTH-bit operands one bit pair per accepted beat, LSB first, and reports eq/gt/lt once the last bit arrives. It sits behind a serialiser in place of the parallel 16-bit equality comparator wherever operand wiring is narrow. It adds greater-than and less-than results and optional signed ordering.

## Interface

Parameters:
- WIDTH, 16: operand width in bits, ≥2.
- SIGNED, 0: 1 = two's-complement ordering; 0 = unsigned.

Ports:
- clk, input, 1: single clock; all logic rising-edge.
- rst_n, input, 1: reset, synchronous and active-low.
- start, input, 1: begin a new comparison; honoured only in IDLE.
- abort, input, 1: drop the current comparison; honoured in SHIFT.
- bit_valid, input, 1: a_bit/b_bit carry a valid bit pair.
- a_bit, input, 1: operand A bit, LSB first.
- b_bit, input, 1: operand B bit, LSB first.
- bit_ready, output, 1: block accepts a bit pair this cycle.
- busy, output, 1: high in SHIFT and DONE.
- done, output, 1: one-cycle pulse; results valid.
- eq, output, 1: A == B.
- gt, output, 1: A > B.
- lt, output, 1: A < B.

## Operation

- States:
  - IDLE: waiting for start.
  - SHIFT: consuming bit pairs.
  - DONE: one cycle, asserting done.
- Transitions:
  - IDLE: start=1 → SHIFT. In the same edge, clear the bit counter, the running result and eq/gt/lt.
  - SHIFT: a beat is accepted when bit_valid && bit_ready. Each accepted beat increments the counter, range 0..WIDTH-1.
  - SHIFT: accepted beat with counter == WIDTH-1 → DONE.
  - SHIFT: abort=1 → IDLE. Abort takes priority over a simultaneous beat, which is discarded. No done pulse; eq/gt/lt stay 0.
  - DONE → IDLE unconditionally. start seen in DONE is ignored.
- Running result is a 2-bit code {EQ, GT, LT}, reset to EQ at start.
- Update rule per accepted beat:
  - a_bit == b_bit: code unchanged.
  - a_bit=1, b_bit=0: code = GT.
  - a_bit=0, b_bit=1: code = LT.
  - Later (more significant) bits therefore override earlier ones.
- SIGNED=1, final beat only (counter == WIDTH-1, sign bit): GT and LT are swapped. A sign bit of 1 means the operand is smaller.
- Result registers:
  - eq/gt/lt load from the final code on the DONE-entry edge.
  - Exactly one of eq/gt/lt is high from then until the next accepted start or reset.
- start, abort and bit_valid outside their honoured states: ignored, no side effects.

## Timing

- Reset: when rst_n is sampled low at a clk edge:
  - state = IDLE, counter = 0, code = EQ.
  - bit_ready = busy = done = eq = gt = lt = 0.
  - Applies mid-comparison: no done pulse, partial result lost.
- bit_ready = 1 exactly when state == SHIFT. It is combinational from the state register, with no dependence on bit_valid.
- start accepted at edge t: busy = bit_ready = 1 from cycle t+1. The earliest first beat is accepted at edge t+1.
- Final beat accepted at edge k: done = 1 and eq/gt/lt valid in cycle k+1; busy = 1 in cycle k+1. State is IDLE in cycle k+2, where done = 0 and busy = 0.
- Minimum latency from start to done is WIDTH+1 cycles with back-to-back valid beats. Gaps in bit_valid stretch it one cycle per idle cycle, with no limit.
- Back-to-back comparisons: the earliest next start is accepted at edge k+2.

## Structure

- Shared package cmp_pkg:
  - cmp_state_t enum {IDLE, SHIFT, DONE}.
  - cmp_res_t enum {CMP_EQ, CMP_GT, CMP_LT}.
  - Reused later by the parallel and serial comparator family.
- Counter width: $clog2(WIDTH), local to the module.
- Single module, no sub-modules. The FSM, counter and result register are small enough to stay flat.

## Test plan

- Unsigned, WIDTH=16: A=0x1234, B=0x1234, 16 contiguous beats → done one cycle after the last beat; eq=1, gt=0, lt=0; outputs held until next start.
- A=0x8000, B=0x7FFF:
  - SIGNED=0 → gt=1.
  - SIGNED=1 → lt=1.
  - A=0x0001, B=0x0002 in either mode → lt=1 (LSB difference overridden by bit 1).
- A=0xFFFE, B=0xFFFF with bit_valid toggling every other cycle → bit_ready stays 1 through SHIFT; done only after the 16th accepted beat; lt=1.
- Abort after 7 beats, asserted together with bit_valid → next cycle busy=0; done never pulses; eq=gt=lt=0. A following start plus 16 beats of A=B=0 → eq=1.
- rst_n driven low for one cycle after 10 beats → all outputs 0 the next cycle. start in DONE ignored. Repeated start in SHIFT ignored, with the counter not cleared.
- Random unsigned and signed operand pairs (≥1000) with random valid gaps, checked against a reference compare → exactly one of eq/gt/lt set, and it matches.
